// File: rtl/instr_adder_ring_meter.sv
// instr_adder_ring_meter
// Measures the frequency of the instrumented adder's ring/chain output. A run
// turns the ring oscillator on for a programmable window of wb_clk_i cycles,
// counts rising edges of the synchronised ring signal and latches the result.
//
// Ports:
//   wb_clk_i     system clock
//   wb_rst_i     synchronous, active-high reset
//   start        request a run; sampled only when idle
//   gate_cycles  window length in wb_clk_i cycles, captured at start
//   ring_in      asynchronous ring/chain output from the adder
//   ring_en      enables the ring oscillator in the adder
//   busy         high from accepted start until the cycle after done
//   done         one-cycle pulse when count/overflow are updated
//   count        last latched edge count
//   overflow     last run saturated the edge counter
//
// Optional feature (macro INSTR_METER_MAX_EN):
//   max_clr      clears max_count; wins over a simultaneous update
//   max_count    largest count latched since reset or last clear

module instr_adder_ring_meter #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned GATE_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ring_in,
    output logic              ring_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
`ifdef INSTR_METER_MAX_EN
    ,
    input  logic              max_clr,
    output logic [CNT_W-1:0]  max_count
`endif
);

    localparam int unsigned ArmW = $clog2(SYNC_STAGES + 1) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StArm   = 2'd1;
    localparam logic [1:0] StCount = 2'd2;
    localparam logic [1:0] StLatch = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [GATE_W-1:0]      timer_q, timer_d;
    logic [ArmW-1:0]        arm_q, arm_d;
    logic [CNT_W-1:0]       live_q, live_d;
    logic                   ovf_live_q, ovf_live_d;
    logic                   ring_en_q, ring_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
`ifdef INSTR_METER_MAX_EN
    logic [CNT_W-1:0]       max_q, max_d;
`endif

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        timer_d    = timer_q;
        arm_d      = arm_q;
        live_d     = live_q;
        ovf_live_d = ovf_live_q;
        ring_en_d  = ring_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;
`ifdef INSTR_METER_MAX_EN
        max_d      = max_q;
`endif

        // busy drops one cycle after the done pulse
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // The done cycle is already IDLE but must not accept a start.
                if (start && !done_q) begin
                    gate_d     = gate_cycles;
                    busy_d     = 1'b1;
                    ring_en_d  = 1'b1;
                    live_d     = '0;
                    ovf_live_d = 1'b0;
                    arm_d      = '0;
                    state_d    = StArm;
                end
            end
            StArm: begin
                // SYNC_STAGES+1 cycles so the synchroniser holds live ring data.
                if (arm_q == ArmW'(SYNC_STAGES)) begin
                    if (gate_q == '0) begin
                        ring_en_d = 1'b0;
                        state_d   = StLatch;
                    end else begin
                        timer_d = gate_q;
                        state_d = StCount;
                    end
                end else begin
                    arm_d = arm_q + 1'b1;
                end
            end
            StCount: begin
                if (rise) begin
                    if (live_q == {CNT_W{1'b1}}) begin
                        ovf_live_d = 1'b1;
                    end else begin
                        live_d = live_q + 1'b1;
                    end
                end
                if (timer_q == GATE_W'(1)) begin
                    ring_en_d = 1'b0;
                    state_d   = StLatch;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StLatch: begin
                count_d    = live_q;
                overflow_d = ovf_live_q;
                done_d     = 1'b1;
                state_d    = StIdle;
`ifdef INSTR_METER_MAX_EN
                if (live_q > max_q) begin
                    max_d = live_q;
                end
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef INSTR_METER_MAX_EN
        if (max_clr) begin
            max_d = '0;
        end
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            gate_q     <= '0;
            timer_q    <= '0;
            arm_q      <= '0;
            live_q     <= '0;
            ovf_live_q <= 1'b0;
            ring_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sync_q     <= '0;
            prev_q     <= 1'b0;
`ifdef INSTR_METER_MAX_EN
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            timer_q    <= timer_d;
            arm_q      <= arm_d;
            live_q     <= live_d;
            ovf_live_q <= ovf_live_d;
            ring_en_q  <= ring_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ring_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
`ifdef INSTR_METER_MAX_EN
            max_q      <= max_d;
`endif
        end
    end

    assign ring_en  = ring_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;
`ifdef INSTR_METER_MAX_EN
    assign max_count = max_q;
`endif

endmodule

// File: tb/tb_instr_adder_ring_meter.sv
// Directed bench for instr_adder_ring_meter. Two instances share stimulus:
// dut_a uses the default 24-bit counter, dut_b a 4-bit counter for saturation.

module tb_instr_adder_ring_meter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ring = 1'b0;
    logic [15:0] gate_cycles = '0;

    logic        ring_en_a, busy_a, done_a, ovf_a;
    logic [23:0] count_a;
    logic        ring_en_b, busy_b, done_b, ovf_b;
    logic [3:0]  count_b;
`ifdef INSTR_METER_MAX_EN
    logic        max_clr = 1'b0;
    logic [23:0] max_a;
    logic [3:0]  max_b;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int ring_mode = 0;
    int ph = 0;
    int lat, en_cyc, got_done, seen;

    always #5 clk = ~clk;

    instr_adder_ring_meter #(.CNT_W(24), .GATE_W(16), .SYNC_STAGES(S)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .gate_cycles(gate_cycles),
        .ring_in(ring), .ring_en(ring_en_a), .busy(busy_a), .done(done_a),
        .count(count_a), .overflow(ovf_a)
`ifdef INSTR_METER_MAX_EN
        , .max_clr(max_clr), .max_count(max_a)
`endif
    );

    instr_adder_ring_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(S)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .gate_cycles(gate_cycles),
        .ring_in(ring), .ring_en(ring_en_b), .busy(busy_b), .done(done_b),
        .count(count_b), .overflow(ovf_b)
`ifdef INSTR_METER_MAX_EN
        , .max_clr(max_clr), .max_count(max_b)
`endif
    );

    // 0: held low, 1: toggle every 2 clocks (period 4), 2: toggle every clock
    always @(posedge clk) begin
        ph <= ph + 1;
        case (ring_mode)
            1: if (ph % 2 == 1) ring <= ~ring;
            2: ring <= ~ring;
            default: ring <= 1'b0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start a run and follow it to the done pulse; hold keeps start high.
    task automatic run(input int gate, input int clr_at, input bit hold);
        gate_cycles = gate[15:0];
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        chk("accept_busy", 32'(busy_a), 1);
        lat = 0;
        en_cyc = ring_en_a ? 1 : 0;
        got_done = 0;
        while (got_done == 0 && lat < gate + 20) begin
`ifdef INSTR_METER_MAX_EN
            if (lat == clr_at) max_clr = 1'b1;
`endif
            step();
            lat++;
`ifdef INSTR_METER_MAX_EN
            max_clr = 1'b0;
`endif
            if (ring_en_a) en_cyc++;
            if (done_a) got_done = 1;
        end
        chk("done_seen", got_done, 1);
        chk("done_latency", lat, S + 2 + gate);
        chk("ring_en_cycles", en_cyc, S + 1 + gate);
        chk("busy_in_done", 32'(busy_a), 1);
    endtask

    task automatic post();
        step();
        chk("done_one_cycle", 32'(done_a), 0);
        chk("busy_falls", 32'(busy_a), 0);
        chk("ring_en_off", 32'(ring_en_a), 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_ring_en", 32'(ring_en_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_count", 32'(count_a), 0);
        chk("rst_overflow", 32'(ovf_a), 0);
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy_a), 0);

        // Basic: period-4 ring over 100 cycles gives 25 rises
        ring_mode = 1;
        repeat (3) step();
        run(100, -1, 1'b0);
        chk("basic_count", 32'(count_a), 25);
        chk("basic_overflow", 32'(ovf_a), 0);
        post();

        // Reset mid-COUNT aborts with no done and clears the result
        gate_cycles = 16'd100;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ring_en", 32'(ring_en_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_count", 32'(count_a), 0);
        seen = 0;
        repeat (150) begin
            step();
            if (done_a) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_count_held", 32'(count_a), 0);

        // Zero window: straight from ARM to LATCH
        run(0, -1, 1'b0);
        chk("zero_count", 32'(count_a), 0);
        chk("zero_overflow", 32'(ovf_a), 0);
        post();

        // Saturation: 32 rises into a 4-bit counter
        ring_mode = 2;
        repeat (3) step();
        run(64, -1, 1'b0);
        chk("sat_count_b", 32'(count_b), 15);
        chk("sat_overflow_b", 32'(ovf_b), 1);
        chk("sat_count_a", 32'(count_a), 32);
        chk("sat_overflow_a", 32'(ovf_a), 0);
        post();

        // Quiet ring clears both count and overflow
        ring_mode = 0;
        repeat (4) step();
        run(64, -1, 1'b0);
        chk("quiet_count_b", 32'(count_b), 0);
        chk("quiet_overflow_b", 32'(ovf_b), 0);
        chk("quiet_count_a", 32'(count_a), 0);
        post();

        // start held through a run (including the done cycle) gives one run
        run(10, -1, 1'b1);
        post();
        start = 1'b0;
        step();
        chk("held_no_rerun_busy", 32'(busy_a), 0);
        chk("held_no_rerun_en", 32'(ring_en_a), 0);
        run(10, -1, 1'b0);
        post();

`ifdef INSTR_METER_MAX_EN
        max_clr = 1'b1;
        step();
        max_clr = 1'b0;
        chk("max_clr_initial", 32'(max_a), 0);
        ring_mode = 1;
        repeat (3) step();
        run(100, -1, 1'b0);
        post();
        run(40, -1, 1'b0);
        chk("max_second_count", 32'(count_a), 10);
        chk("max_keeps_25", 32'(max_a), 25);
        post();
        max_clr = 1'b1;
        step();
        max_clr = 1'b0;
        chk("max_cleared", 32'(max_a), 0);
        run(40, -1, 1'b0);
        chk("max_after_clr", 32'(max_a), 10);
        post();
        run(40, S + 1 + 40, 1'b0);
        chk("max_clr_in_latch", 32'(max_a), 0);
        chk("count_with_clr", 32'(count_a), 10);
        post();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
